// File: rtl/decoy_gen_ml_if.sv
// Symbol-in / decoy-out bundle of the multi-level decoy-state generator.
// The master drives RNG symbols and observes the emitted decoy stream.
interface decoy_gen_ml_if #(
   parameter int RNG_W   = 4,
   parameter int LEVEL_W = 3
) ();
   logic [RNG_W-1:0]   rng_value;
   logic               rd_en;
   logic               decoy_signal;
   logic [LEVEL_W-1:0] decoy_level;
   logic               decoy_valid;

   modport master (
      output rng_value, rd_en,
      input  decoy_signal, decoy_level, decoy_valid
   );

   modport slave (
      input  rng_value, rd_en,
      output decoy_signal, decoy_level, decoy_valid
   );
endinterface

// File: rtl/decoy_gen_ml.sv
// Multi-level decoy-state generator: threshold level map, programmable delay line,
// decoy pulse stretcher, PPS-aligned arm/run control.
module decoy_gen_ml #(
   parameter int RNG_W    = 4,
   parameter int N_LEVELS = 3,
   parameter int LEVEL_W  = 3,
   parameter int DELAY_W  = 4,
   parameter int WIDTH_W  = 4,
   parameter int CNT_W    = 32
) (
   input  logic                            clk240,
   input  logic                            rst_240_n,
   input  logic                            pps_i,
   input  logic                            pps_trigger,
   input  logic                            enable,
   input  logic [(N_LEVELS-1)*RNG_W-1:0]   cfg_thr,
   input  logic [DELAY_W-1:0]              cfg_delay,
   input  logic [WIDTH_W-1:0]              cfg_width,
   decoy_gen_ml_if.slave                   sym,
   output logic                            running,
   output logic [CNT_W-1:0]                sym_count,
   output logic                            overrun
);
   localparam int DEPTH = 2**DELAY_W;

   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
   state_t state;

   logic pps_meta, pps_sync, pps_prev, pps_rise;
   logic go, accept, flush, emit, fire;
   logic [LEVEL_W-1:0] level_map, tap_level, level_hold;
   logic [DEPTH-1:0]              dl_valid;
   logic [DEPTH-1:0][LEVEL_W-1:0] dl_level;
   logic [WIDTH_W-1:0] pulse_cnt;

   assign go     = enable & pps_trigger;
   assign accept = sym.rd_en & running;
   assign flush  = (state == RUN) & ~go;

   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) begin
         pps_meta <= 1'b0;
         pps_sync <= 1'b0;
         pps_prev <= 1'b0;
         pps_rise <= 1'b0;
      end else begin
         pps_meta <= pps_i;
         pps_sync <= pps_meta;
         pps_prev <= pps_sync;
         pps_rise <= pps_sync & ~pps_prev;
      end
   end

   // Count and overrun updates precede the case so the arm-time clear wins.
   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) begin
         state     <= IDLE;
         running   <= 1'b0;
         sym_count <= '0;
         overrun   <= 1'b0;
      end else begin
         if (accept && sym_count != '1)
            sym_count <= sym_count + CNT_W'(1);
         if (fire && pulse_cnt != '0)
            overrun <= 1'b1;
         case (state)
            IDLE: if (go) begin
               state     <= ARMED;
               sym_count <= '0;
               overrun   <= 1'b0;
            end
            ARMED: begin
               if (!go) begin
                  state <= IDLE;
               end else if (pps_rise) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: if (!go) begin
               state   <= IDLE;
               running <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      level_map = '0;
      for (int unsigned k = 0; k < N_LEVELS-1; k++)
         if (sym.rng_value >= cfg_thr[k*RNG_W +: RNG_W])
            level_map = level_map + LEVEL_W'(1);
   end

   assign emit      = dl_valid[cfg_delay];
   assign tap_level = dl_level[cfg_delay];
   assign fire      = emit && (tap_level != '0) && (cfg_width != '0);

   // pulse_cnt holds the remaining cycles after the emission cycle, so a
   // fire cycle itself is high combinationally and the load is width-1.
   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) begin
         dl_valid   <= '0;
         dl_level   <= '0;
         level_hold <= '0;
         pulse_cnt  <= '0;
      end else begin
         dl_valid <= flush ? '0 : {dl_valid[DEPTH-2:0], accept};
         dl_level <= {dl_level[DEPTH-2:0], level_map};
         if (emit)
            level_hold <= tap_level;
         if (flush)
            pulse_cnt <= '0;
         else if (fire)
            pulse_cnt <= cfg_width - WIDTH_W'(1);
         else if (pulse_cnt != '0)
            pulse_cnt <= pulse_cnt - WIDTH_W'(1);
      end
   end

   assign sym.decoy_valid  = emit;
   assign sym.decoy_level  = emit ? tap_level : level_hold;
   assign sym.decoy_signal = fire | (pulse_cnt != '0);
endmodule

// File: tb/tb_decoy_gen_ml.sv
// Directed bench for decoy_gen_ml: arm latency, level map, delay sweep,
// retrigger/overrun, mid-stream disarm and non-monotonic thresholds.
`timescale 1ns/1ps
module tb_decoy_gen_ml;
   logic        clk240 = 1'b0;
   logic        rst_240_n = 1'b0;
   logic        pps_i = 1'b0;
   logic        pps_trigger = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  cfg_thr = '0;
   logic [3:0]  cfg_delay = '0;
   logic [3:0]  cfg_width = '0;
   logic        running;
   logic [31:0] sym_count;
   logic        overrun;
   int          checks = 0;
   int          errors = 0;
   int          lows, nval, nsig;

   decoy_gen_ml_if #(.RNG_W(4), .LEVEL_W(3)) bus ();

   decoy_gen_ml #(
      .RNG_W(4), .N_LEVELS(3), .LEVEL_W(3), .DELAY_W(4), .WIDTH_W(4), .CNT_W(32)
   ) dut (
      .clk240(clk240), .rst_240_n(rst_240_n), .pps_i(pps_i),
      .pps_trigger(pps_trigger), .enable(enable), .cfg_thr(cfg_thr),
      .cfg_delay(cfg_delay), .cfg_width(cfg_width), .sym(bus.slave),
      .running(running), .sym_count(sym_count), .overrun(overrun)
   );

   always #2 clk240 = ~clk240;

   task automatic tick();
      @(posedge clk240);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] v);
      bus.rd_en = 1'b1;
      bus.rng_value = v;
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic wait_run();
      for (int i = 0; i < 8 && !running; i++) tick();
      chk("run_entry", running, 1);
   endtask

   task automatic level_case(input logic [3:0] v, input logic [2:0] lvl, input logic pulse);
      send(v);
      chk("lvl_valid", bus.decoy_valid, 1);
      chk("lvl_level", bus.decoy_level, lvl);
      chk("lvl_sig0", bus.decoy_signal, pulse);
      tick();
      chk("lvl_valid_off", bus.decoy_valid, 0);
      chk("lvl_sig1", bus.decoy_signal, pulse);
      tick();
      chk("lvl_sig2", bus.decoy_signal, 0);
      repeat (3) tick();
   endtask

   task automatic delay_case(input logic [3:0] d);
      cfg_delay = d;
      send(4'd5);
      if (d != 0) begin
         repeat (d-1) tick();
         chk("dly_early", bus.decoy_valid, 0);
         tick();
      end
      chk("dly_hit", bus.decoy_valid, 1);
      repeat (20) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rd_en = 1'b0;
      bus.rng_value = '0;
      // Reset with toggling inputs
      for (int i = 0; i < 25; i++) begin
         pps_i = ~pps_i;
         bus.rd_en = ~bus.rd_en;
         enable = ~enable;
         pps_trigger = ~pps_trigger;
         bus.rng_value = 4'($urandom);
         #4;
      end
      chk("rst_signal", bus.decoy_signal, 0);
      chk("rst_level", bus.decoy_level, 0);
      chk("rst_valid", bus.decoy_valid, 0);
      chk("rst_running", running, 0);
      chk("rst_count", sym_count, 0);
      chk("rst_overrun", overrun, 0);
      pps_i = 1'b0; bus.rd_en = 1'b0; enable = 1'b0; pps_trigger = 1'b0;
      cfg_thr = {4'd8, 4'd4}; cfg_delay = 4'd0; cfg_width = 4'd2;
      tick();
      rst_240_n = 1'b1;
      repeat (4) tick();

      // Arm and exact PPS-to-RUN latency
      enable = 1'b1; pps_trigger = 1'b1;
      tick();
      chk("armed_running", running, 0);
      send(4'd6);
      chk("armed_ignore", sym_count, 0);
      pps_i = 1'b1;
      repeat (3) tick();
      chk("run_early", running, 0);
      tick();
      chk("run_latency", running, 1);
      chk("armed_no_emit", bus.decoy_valid, 0);

      // Level map
      level_case(4'd1, 3'd0, 1'b0);
      level_case(4'd5, 3'd1, 1'b1);
      level_case(4'd12, 3'd2, 1'b1);
      chk("lvl_hold", bus.decoy_level, 2);
      chk("lvl_count", sym_count, 3);
      repeat (20) tick();

      // Delay sweep
      delay_case(4'd0);
      delay_case(4'd7);
      delay_case(4'd15);
      chk("dly_count", sym_count, 6);
      chk("pre_overrun", overrun, 0);

      // Retrigger
      cfg_delay = 4'd0; cfg_width = 4'd10;
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         send(4'd12);
         for (int j = 0; j < 5; j++) begin
            if (!bus.decoy_signal) lows++;
            if (j < 4) tick();
         end
      end
      chk("retrig_lows", lows, 0);
      chk("retrig_overrun", overrun, 1);
      repeat (6) tick();
      chk("retrig_end", bus.decoy_signal, 0);
      chk("retrig_count", sym_count, 10);

      // Re-arm clears overrun and count
      pps_trigger = 1'b0;
      pps_i = 1'b0;
      tick();
      chk("disarm_running", running, 0);
      chk("disarm_ovr_hold", overrun, 1);
      chk("disarm_cnt_hold", sym_count, 10);
      pps_trigger = 1'b1;
      tick();
      chk("rearm_overrun", overrun, 0);
      chk("rearm_count", sym_count, 0);
      repeat (4) tick();
      pps_i = 1'b1;
      wait_run();

      // Disarm mid-stream, exit coincident with an accepted rd_en
      cfg_width = 4'd15;
      send(4'd12);
      tick();
      cfg_delay = 4'd10;
      bus.rd_en = 1'b1; bus.rng_value = 4'd12;
      tick();
      tick();
      chk("pulse_before_exit", bus.decoy_signal, 1);
      pps_trigger = 1'b0;
      tick();
      bus.rd_en = 1'b0;
      chk("exit_running", running, 0);
      chk("exit_signal", bus.decoy_signal, 0);
      chk("exit_count", sym_count, 4);
      nval = 0; nsig = 0;
      for (int i = 0; i < 16; i++) begin
         nval += int'(bus.decoy_valid);
         nsig += int'(bus.decoy_signal);
         tick();
      end
      chk("exit_no_valid", nval, 0);
      chk("exit_no_signal", nsig, 0);
      chk("exit_count_hold", sym_count, 4);
      chk("exit_level_hold", bus.decoy_level, 2);

      // Non-monotonic thresholds: thr[0]=8, thr[1]=4
      pps_i = 1'b0;
      cfg_thr = {4'd4, 4'd8}; cfg_delay = 4'd0; cfg_width = 4'd2;
      send(4'd6);
      chk("idle_ignore", sym_count, 4);
      pps_trigger = 1'b1;
      tick();
      chk("nm_arm_clear", sym_count, 0);
      send(4'd6);
      chk("nm_armed_ignore", sym_count, 0);
      repeat (3) tick();
      pps_i = 1'b1;
      wait_run();
      send(4'd6);
      chk("nm_valid", bus.decoy_valid, 1);
      chk("nm_level6", bus.decoy_level, 1);
      repeat (3) tick();
      send(4'd9);
      chk("nm_level9", bus.decoy_level, 2);
      repeat (3) tick();
      send(4'd3);
      chk("nm_level3", bus.decoy_level, 0);
      chk("nm_count", sym_count, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
